// File: rtl/tile_pixel_fetch.sv
// Tile renderer front end: pixel coordinate -> tile-map select -> sprite select -> 2-bit colour.
// Three-stage valid pipeline; hold freezes every register, including the outputs.
module tile_pixel_fetch #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int TILE_COLS = 40,
  parameter int TILE_ROWS = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_valid,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        hold,
  output logic [11:0] tile_select,
  input  logic [7:0]  tile_code,
  output logic [7:0]  sprite_select,
  input  logic [31:0] sprite_word,
  output logic        out_valid,
  output logic [1:0]  pix_color,
  output logic        frame_done
);

  localparam int TILE_COUNT = TILE_COLS * TILE_ROWS;

  // S1 state
  logic        v1_r;
  logic        in_range1_r;
  logic [3:0]  row1_r;
  logic [3:0]  col1_r;
  logic        last1_r;
  // S2 state
  logic        v2_r;
  logic        blank2_r;
  logic [3:0]  col2_r;
  logic        last2_r;

  logic        in_range_s;
  logic        last_s;
  logic [11:0] tile_index_s;
  logic [11:0] tile_select_next_s;
  logic        blank_next_s;
  logic [7:0]  sprite_select_next_s;
  logic [1:0]  pix_color_next_s;

  // Next-value logic for every stage
  always_comb begin
    in_range_s   = (draw_x < 10'(H_RES)) && (draw_y < 10'(V_RES));
    last_s       = (draw_x == 10'(H_RES - 1)) && (draw_y == 10'(V_RES - 1));
    tile_index_s = 12'(draw_y[9:4]) * 12'(TILE_COLS) + 12'(draw_x[9:4]);
    // The bound check keeps the map mux in range even under odd parameter sets
    if (in_range_s && (tile_index_s < 12'(TILE_COUNT))) begin
      tile_select_next_s = tile_index_s;
    end else begin
      tile_select_next_s = 12'd0;
    end
    blank_next_s = ~in_range1_r | (tile_code[7:4] != 4'd0);
    if (blank_next_s) begin
      sprite_select_next_s = 8'd0;
    end else begin
      sprite_select_next_s = {tile_code[3:0], row1_r};
    end
    if (v2_r && !blank2_r) begin
      pix_color_next_s = sprite_word[{col2_r, 1'b0} +: 2];
    end else begin
      pix_color_next_s = 2'd0;
    end
  end

  // S1: coordinate capture and tile address
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1_r        <= 1'b0;
      in_range1_r <= 1'b0;
      tile_select <= 12'd0;
      row1_r      <= 4'd0;
      col1_r      <= 4'd0;
      last1_r     <= 1'b0;
    end else if (!hold) begin
      v1_r <= pix_valid;
      if (pix_valid) begin
        in_range1_r <= in_range_s;
        tile_select <= tile_select_next_s;
        row1_r      <= draw_y[3:0];
        col1_r      <= draw_x[3:0];
        last1_r     <= last_s;
      end else begin
        in_range1_r <= in_range1_r;
      end
    end else begin
      v1_r <= v1_r;
    end
  end

  // S2: tile code capture and sprite row address
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v2_r          <= 1'b0;
      blank2_r      <= 1'b1;
      sprite_select <= 8'd0;
      col2_r        <= 4'd0;
      last2_r       <= 1'b0;
    end else if (!hold) begin
      v2_r          <= v1_r;
      blank2_r      <= blank_next_s;
      sprite_select <= sprite_select_next_s;
      col2_r        <= col1_r;
      last2_r       <= last1_r;
    end else begin
      v2_r <= v2_r;
    end
  end

  // S3: colour extraction and output flags
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      pix_color  <= 2'd0;
      frame_done <= 1'b0;
    end else if (!hold) begin
      out_valid  <= v2_r;
      pix_color  <= pix_color_next_s;
      frame_done <= v2_r & last2_r;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Bench for tile_pixel_fetch: behavioural tile map / sprite ROM plus a per-pixel
// reference model with a pixel-arrival queue; directed scenarios and a random stream.
module tb_tile_pixel_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        hold;
  logic [11:0] tile_select;
  logic [7:0]  tile_code;
  logic [7:0]  sprite_select;
  logic [31:0] sprite_word;
  logic        out_valid;
  logic [1:0]  pix_color;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tile_map   [0:1199];
  logic [31:0] sprite_rom [0:255];

  typedef struct {
    int       due;
    logic [1:0] color;
    logic     last;
  } exp_t;

  exp_t       exp_q[$];
  int         adv = 0;
  logic       exp_v = 1'b0;
  logic [1:0] exp_c = 2'd0;
  logic       exp_d = 1'b0;
  int         exp_tsel = 0;

  tile_pixel_fetch dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
    .hold(hold), .tile_select(tile_select), .tile_code(tile_code),
    .sprite_select(sprite_select), .sprite_word(sprite_word), .out_valid(out_valid),
    .pix_color(pix_color), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  assign tile_code   = (tile_select < 12'd1200) ? tile_map[tile_select] : 8'h00;
  assign sprite_word = sprite_rom[sprite_select];

  function automatic int ref_tsel(input int x, input int y);
    if (x >= 640 || y >= 480) return 0;
    return (y / 16) * 40 + (x / 16);
  endfunction

  function automatic logic [1:0] ref_color(input int x, input int y);
    int code;
    logic [31:0] word;
    if (x >= 640 || y >= 480) return 2'd0;
    code = int'(tile_map[ref_tsel(x, y)]);
    if (code >= 16) return 2'd0;
    word = sprite_rom[(code % 16) * 16 + (y % 16)];
    return 2'((word >> (2 * (x % 16))) & 32'd3);
  endfunction

  // One clock: present inputs, take the edge, advance the reference model, settle.
  task automatic drive_cycle(input logic v, input int x, input int y, input logic h);
    pix_valid = v;
    draw_x    = x[9:0];
    draw_y    = y[9:0];
    hold      = h;
    @(posedge Clk);
    if (!h) begin
      adv++;
      if (v) begin
        exp_q.push_back('{due: adv + 2, color: ref_color(x, y), last: (x == 639 && y == 479)});
        exp_tsel = ref_tsel(x, y);
      end
      if (exp_q.size() > 0 && exp_q[0].due == adv) begin
        exp_v = 1'b1;
        exp_c = exp_q[0].color;
        exp_d = exp_q[0].last;
        void'(exp_q.pop_front());
      end else begin
        exp_v = 1'b0;
        exp_d = 1'b0;
      end
    end
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_v = 1'b0;
    exp_d = 1'b0;
    exp_c = 2'd0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, frame_done, pix_color, tile_select, sprite_select} !== 24'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b fd=%b c=%0d ts=%0d ss=%0d want all 0",
               out_valid, frame_done, pix_color, tile_select, sprite_select);
    end
    Reset = 1'b0;
    drive_cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got v=%b fd=%b want 0 0", out_valid, frame_done);
    end
  endtask

  task automatic test_single_pixel();
    tile_map[122] = 8'h07;
    sprite_rom[8'h72][11:10] = 2'b10;
    drive_cycle(1'b1, 37, 50, 1'b0);
    checks++;
    if (tile_select !== 12'd122) begin
      failures++; $display("FAIL single_tsel got=%0d want=122", tile_select);
    end
    drive_cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (sprite_select !== 8'h72 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_ssel got=%h v=%b want=72 v=0", sprite_select, out_valid);
    end
    drive_cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || pix_color !== 2'd2) begin
      failures++; $display("FAIL single_out got v=%b c=%0d want v=1 c=2", out_valid, pix_color);
    end
    drive_cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL single_after got v=%b want 0", out_valid);
    end
    model_clear();
  endtask

  task automatic test_row_stream();
    for (int i = 0; i < 40; i++) tile_map[i] = 8'(i);
    for (int i = 0; i < 644; i++) begin
      drive_cycle(i < 640, (i < 640) ? i : 0, 0, 1'b0);
      if (i < 640) begin
        checks++;
        if (tile_select !== 12'(i / 16)) begin
          failures++; $display("FAIL row_tsel x=%0d got=%0d want=%0d", i, tile_select, i / 16);
        end
      end
      checks++;
      if (out_valid !== exp_v || frame_done !== exp_d) begin
        failures++;
        $display("FAIL row_flags i=%0d got v=%b fd=%b want v=%b fd=%b", i, out_valid, frame_done, exp_v, exp_d);
      end
      if (exp_v) begin
        checks++;
        if (pix_color !== exp_c) begin
          failures++; $display("FAIL row_color i=%0d got=%0d want=%0d", i, pix_color, exp_c);
        end
      end
    end
  endtask

  task automatic test_frame_end();
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i == 0, 639, 479, 1'b0);
      if (i == 0) begin
        checks++;
        if (tile_select !== 12'd1199) begin
          failures++; $display("FAIL frame_tsel got=%0d want=1199", tile_select);
        end
      end
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (frame_done !== exp_d || out_valid !== exp_v) begin
        failures++;
        $display("FAIL frame_flags i=%0d got v=%b fd=%b want v=%b fd=%b", i, out_valid, frame_done, exp_v, exp_d);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL frame_pulses got=%0d want=1", pulses);
    end
    // Pulse landing under hold must stretch, not vanish
    for (int i = 0; i < 7; i++) begin
      drive_cycle(i == 0, 639, 479, (i == 3 || i == 4));
      checks++;
      if (frame_done !== exp_d || out_valid !== exp_v) begin
        failures++;
        $display("FAIL frame_hold i=%0d got v=%b fd=%b want v=%b fd=%b", i, out_valid, frame_done, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_out_of_range();
    tile_map[0] = 8'h15;
    drive_cycle(1'b1, 640, 0, 1'b0);
    checks++;
    if (tile_select !== 12'd0) begin
      failures++; $display("FAIL oor_tsel_x got=%0d want=0", tile_select);
    end
    drive_cycle(1'b1, 0, 480, 1'b0);
    checks++;
    if (tile_select !== 12'd0 || sprite_select !== 8'd0) begin
      failures++; $display("FAIL oor_tsel_y got ts=%0d ss=%0d want 0 0", tile_select, sprite_select);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 0, 0, 1'b0);
      checks++;
      if (out_valid !== exp_v || (exp_v && pix_color !== 2'd0) || sprite_select !== 8'd0) begin
        failures++;
        $display("FAIL oor_out i=%0d got v=%b c=%0d ss=%0d want v=%b c=0 ss=0", i, out_valid, pix_color, sprite_select, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 24; i++) begin
      drive_cycle(1'b1, 200 + i, 100, (i >= 6 && i < 11));
      checks++;
      if (out_valid !== exp_v || frame_done !== exp_d || tile_select !== 12'(exp_tsel)) begin
        failures++;
        $display("FAIL hold_flags i=%0d got v=%b fd=%b ts=%0d want v=%b fd=%b ts=%0d",
                 i, out_valid, frame_done, tile_select, exp_v, exp_d, exp_tsel);
      end
      if (exp_v) begin
        checks++;
        if (pix_color !== exp_c) begin
          failures++; $display("FAIL hold_color i=%0d got=%0d want=%0d", i, pix_color, exp_c);
        end
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16 * i, 32, 1'b0);
    Reset = 1'b1;
    #1;
    model_clear();
    checks++;
    if ({out_valid, frame_done, pix_color, tile_select, sprite_select} !== 24'd0) begin
      failures++;
      $display("FAIL midreset_async got v=%b fd=%b c=%0d ts=%0d ss=%0d want all 0",
               out_valid, frame_done, pix_color, tile_select, sprite_select);
    end
    pix_valid = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(i == 3, 300, 200, 1'b0);
      checks++;
      if (out_valid !== (i == 5)) begin
        failures++; $display("FAIL midreset_latency i=%0d got v=%b want %b", i, out_valid, (i == 5));
      end
      if (i == 5) begin
        checks++;
        if (pix_color !== ref_color(300, 200)) begin
          failures++; $display("FAIL midreset_color got=%0d want=%0d", pix_color, ref_color(300, 200));
        end
      end
    end
    model_clear();
  endtask

  task automatic test_random();
    int x, y;
    logic v, h;
    for (int i = 0; i < 1200; i++) tile_map[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
    for (int i = 0; i < 256; i++) sprite_rom[i] = $urandom;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 7) == 0);
      x = (i % 50 == 7) ? 639 : int'($urandom_range(0, 700));
      y = (i % 50 == 7) ? 479 : int'($urandom_range(0, 520));
      drive_cycle(v, x, y, h);
      checks++;
      if (out_valid !== exp_v || frame_done !== exp_d) begin
        failures++;
        $display("FAIL rand_flags i=%0d got v=%b fd=%b want v=%b fd=%b", i, out_valid, frame_done, exp_v, exp_d);
      end
      if (exp_v) begin
        checks++;
        if (pix_color !== exp_c) begin
          failures++; $display("FAIL rand_color i=%0d got=%0d want=%0d", i, pix_color, exp_c);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) tile_map[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) sprite_rom[i] = $urandom;
    Reset = 1'b1;
    pix_valid = 1'b0;
    draw_x = 10'd0;
    draw_y = 10'd0;
    hold = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_single_pixel();
    test_row_stream();
    test_frame_end();
    test_out_of_range();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
